riscv_mc_control: RTL and testbench

Multicycle control unit that sequences the RISC-V datapath through fetch, decode, execute, memory and writeback for the supported subset: add, sub, and, or, addi, lw, sw, beq. It sits beside the datapath and drives its register, ALU, PC and memory enables from a state machine. It handshakes with instruction and data memory, counts retired instructions, and traps permanently on an unsupported encoding.

---
 rtl/riscv_mc_control.sv | 191 +++++++++++++++++++
 tb/tb_riscv_mc_control.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_control.sv
// Multicycle control unit for an RV32 subset (add/sub/and/or/addi/lw/sw/beq).
// Registered state and retire counter; enables are decoded combinationally and gated by reset.
module riscv_mc_control #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             zero,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_branch,
    output logic             reg_write,
    output logic             alu_src,
    output logic [1:0]       alu_ctrl,
    output logic [1:0]       imm_sel,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_ILL
    } op_t;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STORE= 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;

    state_t           state_q, state_d;
    op_t              op;
    logic [CNT_W-1:0] count_q;
    logic             retire;
    logic [6:0]       opcode, funct7;
    logic [2:0]       funct3;
    logic [4:0]       rd;
    logic             op_alu_src;
    logic [1:0]       op_alu_ctrl, op_imm_sel;
    logic             imem_req_c, ir_write_c, pc_write_c, pc_branch_c, reg_write_c;
    logic             alu_src_c, mem_read_c, mem_write_c, mem_to_reg_c, illegal_c;
    logic [1:0]       alu_ctrl_c, imm_sel_c;
    logic             unused_fields;

    assign opcode        = instruction[6:0];
    assign rd            = instruction[11:7];
    assign funct3        = instruction[14:12];
    assign funct7        = instruction[31:25];
    assign unused_fields = ^instruction[24:15];

    // Instruction classification from the IR contents.
    always_comb begin
        op = OP_ILL;
        case (opcode)
            OPC_R: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000)      op = OP_ADD;
                else if (funct3 == 3'b000 && funct7 == 7'b0100000) op = OP_SUB;
                else if (funct3 == 3'b111 && funct7 == 7'b0000000) op = OP_AND;
                else if (funct3 == 3'b110 && funct7 == 7'b0000000) op = OP_OR;
            end
            OPC_I:     if (funct3 == 3'b000) op = OP_ADDI;
            OPC_LOAD:  if (funct3 == 3'b010) op = OP_LW;
            OPC_STORE: if (funct3 == 3'b010) op = OP_SW;
            OPC_BR:    if (funct3 == 3'b000) op = OP_BEQ;
            default:   op = OP_ILL;
        endcase
    end

    // ALU operand/function selection per instruction, held from EXEC through WB.
    always_comb begin
        op_alu_src  = 1'b1;
        op_alu_ctrl = 2'b00;
        op_imm_sel  = 2'b00;
        case (op)
            OP_ADD:  op_alu_src = 1'b0;
            OP_SUB:  begin op_alu_src = 1'b0; op_alu_ctrl = 2'b01; end
            OP_AND:  begin op_alu_src = 1'b0; op_alu_ctrl = 2'b10; end
            OP_OR:   begin op_alu_src = 1'b0; op_alu_ctrl = 2'b11; end
            OP_SW:   op_imm_sel = 2'b01;
            OP_BEQ:  begin op_alu_src = 1'b0; op_alu_ctrl = 2'b01; op_imm_sel = 2'b10; end
            default: ;
        endcase
    end

    // Next state, retire strobe and raw enables.
    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        imem_req_c   = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        pc_branch_c  = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_c    = 1'b0;
        alu_ctrl_c   = 2'b00;
        imm_sel_c    = 2'b00;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        illegal_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: state_d = (op == OP_ILL) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                alu_src_c  = op_alu_src;
                alu_ctrl_c = op_alu_ctrl;
                imm_sel_c  = op_imm_sel;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_BEQ: begin
                        pc_branch_c = zero;
                        retire      = 1'b1;
                        state_d     = S_FETCH;
                    end
                    OP_ILL:  state_d = S_TRAP;
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                alu_src_c   = op_alu_src;
                alu_ctrl_c  = op_alu_ctrl;
                imm_sel_c   = op_imm_sel;
                mem_write_c = (op == OP_SW);
                mem_read_c  = (op != OP_SW);
                if (dmem_ready) begin
                    retire  = (op == OP_SW);
                    state_d = (op == OP_SW) ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                alu_src_c    = op_alu_src;
                alu_ctrl_c   = op_alu_ctrl;
                reg_write_c  = (rd != 5'd0);
                mem_to_reg_c = (op == OP_LW);
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP:  illegal_c = 1'b1;
            default: state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) count_q <= count_q + CNT_W'(1);
        end
    end

    // Reset kills every enable in the same cycle so an in-flight access aborts cleanly.
    assign imem_req    = reset & imem_req_c;
    assign ir_write    = reset & ir_write_c;
    assign pc_write    = reset & pc_write_c;
    assign pc_branch   = reset & pc_branch_c;
    assign reg_write   = reset & reg_write_c;
    assign alu_src     = reset & alu_src_c;
    assign alu_ctrl    = reset ? alu_ctrl_c : 2'b00;
    assign imm_sel     = reset ? imm_sel_c : 2'b00;
    assign mem_read    = reset & mem_read_c;
    assign mem_write   = reset & mem_write_c;
    assign mem_to_reg  = reset & mem_to_reg_c;
    assign illegal     = reset & illegal_c;
    assign state       = 3'(state_q);
    assign instr_count = count_q;

endmodule

// File: tb/tb_riscv_mc_control.sv
// Randomized bench for riscv_mc_control; per-instruction expectations come from
// latency/enable totals derived from the instruction class and injected wait states.
module tb_riscv_mc_control;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [31:0]      instruction = 32'd0;
    logic             imem_ready = 1'b0, dmem_ready = 1'b0, zero = 1'b0;
    logic             imem_req, ir_write, pc_write, pc_branch, reg_write, alu_src;
    logic [1:0]       alu_ctrl, imm_sel;
    logic             mem_read, mem_write, mem_to_reg, illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;

    int n_total = 0;
    int n_bad   = 0;
    int exp_cnt = 0;

    // Class 0..7: add sub and or addi lw sw beq
    int base_lat [8] = '{4, 4, 4, 4, 4, 5, 4, 3};
    int exp_ctrl [8] = '{0, 1, 2, 3, 0, 0, 0, 1};
    int exp_src  [8] = '{0, 0, 0, 0, 1, 1, 1, 0};
    int exp_isel [8] = '{0, 0, 0, 0, 0, 0, 1, 2};
    logic [31:0] bad_enc [6] = '{32'hFFFFFFFF, 32'h022080B3, 32'h00109093,
                                 32'h00400083, 32'h00209463, 32'h4020F0B3};

    riscv_mc_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .zero(zero),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
        .pc_branch(pc_branch), .reg_write(reg_write), .alu_src(alu_src),
        .alu_ctrl(alu_ctrl), .imm_sel(imm_sel), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .illegal(illegal),
        .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] encode(input int cls, input logic [4:0] rd);
        logic [31:0] r;
        logic [4:0]  rs1, rs2;
        logic [11:0] imm;
        r   = $urandom;
        rs1 = r[19:15];
        rs2 = r[24:20];
        imm = r[31:20];
        case (cls)
            0: return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            1: return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            2: return {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
            3: return {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
            4: return {imm, rs1, 3'b000, rd, 7'b0010011};
            5: return {imm, rs1, 3'b010, rd, 7'b0000011};
            6: return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            default: return {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'b1100011};
        endcase
    endfunction

    function automatic logic [31:0] enables();
        return 32'({imem_req, ir_write, pc_write, pc_branch, reg_write, alu_src, alu_ctrl,
                    imm_sel, mem_read, mem_write, mem_to_reg, illegal});
    endfunction

    // Hold reset low for three edges, then release and expect an immediate fetch request.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
        #1 check("rst_enables", enables(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        reset = 1'b1; imem_ready = 1'b0;
        #1 check("rst_first_req", 32'(imem_req), 32'd1);
    endtask

    // f = FETCH wait cycles, m = MEM wait cycles, zsel < 0 means random zero flag.
    task automatic run_instr(input int cls, input logic [31:0] ins, input int f,
                             input int m, input int zsel);
        int   lat, n_req, n_irw, n_pcw, n_rd, n_wr, n_rw, n_m2r, n_pcb, n_ill;
        logic z_exec;
        bit   memop, writes;
        n_req = 0; n_irw = 0; n_pcw = 0; n_rd = 0; n_wr = 0;
        n_rw = 0; n_m2r = 0; n_pcb = 0; n_ill = 0; z_exec = 1'b0;
        memop  = (cls == 5 || cls == 6);
        writes = (cls <= 5) && (ins[11:7] != 5'd0);
        lat    = base_lat[cls] + f + (memop ? m : 0);
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            instruction = (k <= f) ? 32'($urandom) : ins;
            imem_ready  = (k < f) ? 1'b0 : (k == f) ? 1'b1 : 1'($urandom % 2);
            if (memop && k >= f + 3) dmem_ready = (k < f + 3 + m) ? 1'b0 : 1'b1;
            else                     dmem_ready = 1'($urandom % 2);
            zero = (zsel < 0) ? 1'($urandom % 2) : 1'(zsel);
            if (k == f + 2) z_exec = zero;
            #1;
            n_req += int'(imem_req);  n_irw += int'(ir_write);  n_pcw += int'(pc_write);
            n_rd  += int'(mem_read);  n_wr  += int'(mem_write); n_rw  += int'(reg_write);
            n_m2r += int'(mem_to_reg); n_pcb += int'(pc_branch); n_ill += int'(illegal);
            if (k == f) check("fetch_irw_pcw", 32'({ir_write, pc_write}), 32'd3);
            if (k == f + 2) begin
                check("exec_alu_ctrl", 32'(alu_ctrl), 32'(exp_ctrl[cls]));
                check("exec_alu_src", 32'(alu_src), 32'(exp_src[cls]));
                if (cls >= 4) check("exec_imm_sel", 32'(imm_sel), 32'(exp_isel[cls]));
            end
        end
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        check("cnt_imem_req", 32'(n_req), 32'(f + 1));
        check("cnt_ir_write", 32'(n_irw), 32'd1);
        check("cnt_pc_write", 32'(n_pcw), 32'd1);
        check("cnt_mem_read", 32'(n_rd), (cls == 5) ? 32'(m + 1) : 32'd0);
        check("cnt_mem_write", 32'(n_wr), (cls == 6) ? 32'(m + 1) : 32'd0);
        check("cnt_reg_write", 32'(n_rw), writes ? 32'd1 : 32'd0);
        check("cnt_mem_to_reg", 32'(n_m2r), (cls == 5) ? 32'd1 : 32'd0);
        check("cnt_pc_branch", 32'(n_pcb), (cls == 7) ? 32'(z_exec) : 32'd0);
        check("cnt_illegal", 32'(n_ill), 32'd0);
        @(posedge clk);
        #1;
        check("retire_count", 32'(instr_count), 32'(exp_cnt));
        check("next_fetch", 32'(state), 32'd0);
    endtask

    // Illegal encoding: fetch, decode, then TRAP for ten observed cycles.
    task automatic run_illegal(input logic [31:0] ins, input int f);
        int n_trap;
        n_trap = 0;
        for (int k = 0; k < f + 12; k++) begin
            @(negedge clk);
            instruction = (k <= f) ? 32'($urandom) : ins;
            imem_ready  = (k < f) ? 1'b0 : (k == f) ? 1'b1 : 1'($urandom % 2);
            dmem_ready  = 1'($urandom % 2);
            zero        = 1'($urandom % 2);
            #1;
            if (k > f + 1 && state == 3'd5 && illegal && !imem_req && enables() == 32'd1)
                n_trap++;
        end
        check("trap_cycles", 32'(n_trap), 32'd10);
        check("trap_count", 32'(instr_count), 32'(exp_cnt));
    endtask

    initial begin
        logic [31:0] ins;
        int          cls;
        do_reset();

        run_instr(0, 32'h002080B3, 0, 0, -1);
        run_instr(5, 32'h00402083, 0, 2, -1);
        run_instr(6, 32'h00202223, 0, 0, -1);
        run_instr(7, 32'h00208463, 0, 0, 1);
        run_instr(7, 32'h00208463, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 16; i++) run_instr(4, 32'h00500013, 0, 0, -1);
        check("wrap_to_zero", 32'(instr_count), 32'd0);

        for (int i = 0; i < 80; i++) begin
            cls = int'($urandom % 8);
            ins = encode(cls, ($urandom % 4 == 0) ? 5'd0 : 5'($urandom));
            run_instr(cls, ins, int'($urandom % 3), int'($urandom % 3), -1);
        end

        // lw stalled in MEM, then reset drops mem_read in the same cycle.
        ins = encode(5, 5'd3);
        @(negedge clk); instruction = 32'($urandom); imem_ready = 1'b1; dmem_ready = 1'b0;
        @(negedge clk); instruction = ins; imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 check("stall_mem_read", 32'(mem_read), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1 check("abort_enables", enables(), 32'd0);
        @(posedge clk);
        #1 check("abort_state", 32'(state), 32'd0);
        do_reset();

        for (int i = 0; i < 6; i++) begin
            run_illegal(bad_enc[i], int'($urandom % 3));
            do_reset();
        end
        run_instr(0, 32'h002080B3, 1, 0, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
